// File: rtl/adder4_exerciser_if.sv
// adder4_exerciser_if
//   Pin-level bundle between an adder4 exerciser and whoever controls it.
//   Signals:
//     ena, start        - control into the exerciser
//     stim_out          - operand byte to the adder ([3:0]=a, [7:4]=b)
//     resp_in           - adder result byte ([4:0]=a+b)
//     busy, done, pass  - sweep status
//     err_count         - mismatches in the last sweep (0..256)
//     first_fail(_valid)- stimulus byte of the first mismatch
//   Modports:
//     master - controller / adder side (drives ena, start, resp_in)
//     slave  - exerciser side (drives stim_out and status)
interface adder4_exerciser_if;
  logic       ena;
  logic       start;
  logic [7:0] stim_out;
  logic [7:0] resp_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] first_fail;
  logic       first_fail_valid;

  modport master (
    output ena, start, resp_in,
    input  stim_out, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  modport slave (
    input  ena, start, resp_in,
    output stim_out, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/adder4_exerciser.sv
// adder4_exerciser
//   Stimulus generator / response checker for the tt_um_adder4 pin interface.
//   On an accepted start it sweeps all 256 operand bytes, holds each one for
//   DUT_LATENCY+1 cycles, samples resp_in at the last edge of that window and
//   compares the masked response with the ideal 5-bit sum.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - adder4_exerciser_if.slave (ena, start, resp_in in;
//              stim_out, busy, done, pass, err_count, first_fail,
//              first_fail_valid out). All outputs are registered.
//   Parameters:
//     DUT_LATENCY - cycles from a stim_out change to a valid resp_in (0..15)
//     RESULT_MASK - resp_in bits that take part in the comparison
module adder4_exerciser #(
  parameter int         DUT_LATENCY = 1,
  parameter logic [7:0] RESULT_MASK = 8'h1F
) (
  input  logic                clk,
  input  logic                rst_n,
  adder4_exerciser_if.slave   bus
);

  // Per-vector state sequence:
  //   DUT_LATENCY == 0 : DRIVE (samples on its own exit edge)
  //   DUT_LATENCY == 1 : DRIVE, CHECK
  //   DUT_LATENCY >= 2 : DRIVE, WAIT x (DUT_LATENCY-1), CHECK
  // so every vector occupies exactly DUT_LATENCY+1 enabled cycles and the
  // response is taken on the edge that also advances stim_out.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((DUT_LATENCY >= 2) ? DUT_LATENCY - 2 : 0);

  state_t     state_q, state_d;
  logic [7:0] v_q, v_d;            // current vector, also drives stim_out
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;

  logic       accept;
  logic       sample;
  logic       last_vec;
  logic [4:0] sum;
  logic [7:0] exp_resp;
  logic       mismatch;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    accept   = bus.ena && bus.start && (state_q == S_IDLE || state_q == S_DONE);
    sample   = bus.ena && ((state_q == S_CHECK) ||
                           (state_q == S_DRIVE && DUT_LATENCY == 0));
    last_vec = (v_q == 8'hFF);
    sum      = {1'b0, v_q[3:0]} + {1'b0, v_q[7:4]};
    exp_resp = {3'b000, sum};
    mismatch = |((bus.resp_in ^ exp_resp) & RESULT_MASK);
  end

  // ---------------------------------------------------------------------------
  // State register (and datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      v_q        <= 8'h00;
      wait_cnt_q <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 9'h000;
      ff_q       <= 8'h00;
      ffv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      ffv_q      <= ffv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          if (DUT_LATENCY == 0)      state_d = last_vec ? S_DONE : S_DRIVE;
          else if (DUT_LATENCY == 1) state_d = S_CHECK;
          else                       state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = last_vec ? S_DONE : S_DRIVE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    v_d        = v_q;
    wait_cnt_d = wait_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;

    if (accept) begin
      v_d        = 8'h00;
      wait_cnt_d = 4'h0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      err_d      = 9'h000;
      ff_d       = 8'h00;
      ffv_d      = 1'b0;
    end

    if (bus.ena && state_q == S_DRIVE) wait_cnt_d = 4'h0;
    if (bus.ena && state_q == S_WAIT)  wait_cnt_d = wait_cnt_q + 4'h1;

    if (sample) begin
      // At most 256 mismatches fit in 9 bits, so the counter never wraps.
      err_d = err_q + {8'h00, mismatch};
      if (mismatch && !ffv_q) begin
        ff_d  = v_q;
        ffv_d = 1'b1;
      end
      if (last_vec) begin
        // stim_out parks at 8'hFF; no second sweep without a new start.
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_d == 9'h000);
      end else begin
        v_d = v_q + 8'h01;
      end
    end
  end

  assign bus.stim_out         = v_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_adder4_exerciser.sv
// tb_adder4_exerciser
//   Three exerciser instances (latency 1 / mask 1F, latency 0 / mask 1F,
//   latency 3 / mask FF), each facing a behavioural adder with selectable
//   fault. A vector table drives whole sweeps; hand sequences cover reset,
//   ena-in-idle, re-arm and asynchronous reset mid-sweep.
module tb_adder4_exerciser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]      start_r;
  logic [2:0]      ena_r;
  int              fault_m [3];   // 0 ideal, 1 resp[0] stuck 0, 2 resp[7] stuck 1
  logic [2:0][7:0] stim_o;
  logic [2:0]      busy_o, done_o, pass_o, ffv_o;
  logic [2:0][8:0] err_o;
  logic [2:0][7:0] ff_o;

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int         LAT  = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
    localparam logic [7:0] MASK = (gi == 2) ? 8'hFF : 8'h1F;

    adder4_exerciser_if bus ();
    logic [7:0] r, p1, p2, p3;

    always_comb begin
      r = {3'b000, 5'(bus.stim_out[3:0]) + 5'(bus.stim_out[7:4])};
      if (fault_m[gi] == 1) r[0] = 1'b0;
      if (fault_m[gi] == 2) r[7] = 1'b1;
    end

    always @(posedge clk) begin
      p1 <= r;
      p2 <= p1;
      p3 <= p2;
    end

    assign bus.resp_in = (LAT == 0) ? r : (LAT == 1) ? p1 : p3;
    assign bus.start   = start_r[gi];
    assign bus.ena     = ena_r[gi];
    assign stim_o[gi]  = bus.stim_out;
    assign busy_o[gi]  = bus.busy;
    assign done_o[gi]  = bus.done;
    assign pass_o[gi]  = bus.pass;
    assign err_o[gi]   = bus.err_count;
    assign ff_o[gi]    = bus.first_fail;
    assign ffv_o[gi]   = bus.first_fail_valid;

    adder4_exerciser #(.DUT_LATENCY(LAT), .RESULT_MASK(MASK)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         inst;
    int         fault;
    int         restart_at;
    int         ena_at;
    int         ena_len;
    int         cycles;
    logic       pass;
    logic [8:0] err;
    logic [7:0] ff;
    logic       ffv;
  } row_t;

  // One sweep: start is accepted at edge E0; n counts edges after E0.
  // eff counts only enabled edges, which is what drives stim_out.
  task automatic sweep(input int i, input int restart_at, input int ena_at,
                       input int ena_len, output int n_done, output int stim_bad);
    int   lat, nn, n, eff, off;
    logic en_before;
    lat = lat_of(i);
    nn  = 256 * (lat + 1);
    n = 0; eff = 0; off = 0; stim_bad = 0; n_done = -1;
    start_r[i] = 1'b1;
    @(posedge clk); #1;
    start_r[i] = 1'b0;
    while (n < nn + ena_len + 50) begin
      if (done_o[i]) begin
        n_done = n;
        break;
      end
      if (stim_o[i] != 8'(eff / (lat + 1))) stim_bad++;
      start_r[i] = (n == restart_at);
      if (n == ena_at) ena_r[i] = 1'b0;
      en_before = ena_r[i];
      @(posedge clk); #1;
      n++;
      if (en_before) eff++;
      else begin
        off++;
        if (off == ena_len) ena_r[i] = 1'b1;
      end
    end
    start_r[i] = 1'b0;
    ena_r[i]   = 1'b1;
  endtask

  task automatic run_row(input string tag, input row_t r);
    int n_done, stim_bad;
    fault_m[r.inst] = r.fault;
    sweep(r.inst, r.restart_at, r.ena_at, r.ena_len, n_done, stim_bad);
    chk({tag, "_cycles"},   n_done,            r.cycles);
    chk({tag, "_stimseq"},  stim_bad,          0);
    chk({tag, "_busy"},     busy_o[r.inst],    1'b0);
    chk({tag, "_pass"},     pass_o[r.inst],    r.pass);
    chk({tag, "_err"},      err_o[r.inst],     r.err);
    chk({tag, "_ff"},       ff_o[r.inst],      r.ff);
    chk({tag, "_ffv"},      ffv_o[r.inst],     r.ffv);
    chk({tag, "_stimend"},  stim_o[r.inst],    8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, {done_o[r.inst], busy_o[r.inst], stim_o[r.inst]}, {2'b10, 8'hFF});
  endtask

  row_t rows [9];

  initial begin
    int   n;
    row_t post;

    rows[0] = '{0, 0,  -1,  -1,  0,  512, 1'b1, 9'd0,   8'h00, 1'b0};
    rows[1] = '{0, 1,  -1,  -1,  0,  512, 1'b0, 9'd128, 8'h01, 1'b1};
    rows[2] = '{0, 2,  -1,  -1,  0,  512, 1'b1, 9'd0,   8'h00, 1'b0};
    rows[3] = '{0, 1, 100,  -1,  0,  512, 1'b0, 9'd128, 8'h01, 1'b1};
    rows[4] = '{0, 1,  -1, 200, 37,  549, 1'b0, 9'd128, 8'h01, 1'b1};
    rows[5] = '{1, 0,  -1,  -1,  0,  256, 1'b1, 9'd0,   8'h00, 1'b0};
    rows[6] = '{1, 1,  -1,  -1,  0,  256, 1'b0, 9'd128, 8'h01, 1'b1};
    rows[7] = '{2, 2,  -1,  -1,  0, 1024, 1'b0, 9'd256, 8'h00, 1'b1};
    rows[8] = '{2, 0,  -1,  -1,  0, 1024, 1'b1, 9'd0,   8'h00, 1'b0};

    for (int i = 0; i < 3; i++) fault_m[i] = 0;
    start_r = '0;
    ena_r   = '1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_%0d", i),
          {stim_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], ff_o[i], ffv_o[i]}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ena low in IDLE: start must be ignored
    ena_r[0]   = 1'b0;
    start_r[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_ena_low_busy", busy_o[0], 1'b0);
    start_r[0] = 1'b0;
    ena_r[0]   = 1'b1;
    @(posedge clk); #1;
    chk("idle_ena_low_after", {busy_o[0], stim_o[0]}, 9'h000);

    for (int k = 0; k < 9; k++) run_row($sformatf("row%0d", k), rows[k]);

    // Re-arm: start held high through DONE restarts on the next edge
    fault_m[1] = 0;
    start_r[1] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done_o[1] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rearm_first_cycles", n, 256);
    @(posedge clk); #1;
    chk("rearm_restart", {done_o[1], busy_o[1], stim_o[1]}, {2'b01, 8'h00});
    n = 0;
    while (!done_o[1] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rearm_second_cycles", n, 256);
    chk("rearm_second_pass", pass_o[1], 1'b1);
    start_r[1] = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset at cycle 300 of a faulty sweep
    fault_m[0] = 1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy_o[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {stim_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], ff_o[0], ffv_o[0]}, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    post = '{0, 0, -1, -1, 0, 512, 1'b1, 9'd0, 8'h00, 1'b0};
    run_row("post_reset", post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
